// File: rtl/stdio_pkg.sv
// Shared types and constants for the STDIN/STDOUT sequencer.
// The optional STDIO_COUNT_EN build adds transfer counters to stdio_controller.
package stdio_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int STDIO_XLEN     = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RX_WAIT = 2'd1,
    TX_WAIT = 2'd2,
    DONE    = 2'd3
  } stdio_state_e;

endpackage

// File: rtl/stdio_rx_fifo.sv
// Small RX byte FIFO between the UART receiver and the STDIN sequencer.
// A push into a full FIFO only succeeds when a pop frees a slot in the same cycle.
module stdio_rx_fifo
  import stdio_pkg::*;
#(
  parameter int RX_DEPTH = 4,
  parameter int DATA_W   = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic              overflow_pulse
);

  localparam int AW = $clog2(RX_DEPTH);

  // One extra pointer bit separates the full and empty cases.
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [RX_DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty          = (wr_ptr_q == rd_ptr_q);
  assign full           = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop         = pop & ~empty;
  assign do_push        = push & (~full | do_pop);
  assign overflow_pulse = push & full & ~do_pop;
  assign pop_data       = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/stdio_controller.sv
// Multi-cycle sequencer for STDIN/STDOUT instructions between the core and the UART.
// Define STDIO_COUNT_EN to add the rx_count / tx_count transfer counters.
module stdio_controller
  import stdio_pkg::*;
#(
  parameter int RX_DEPTH = 4,
  parameter int DATA_W   = DEFAULT_DATA_W
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  stdin_read_enable,
  input  logic                  stdout_write_enable,
  input  logic [STDIO_XLEN-1:0] stdout_data,
  output logic                  stall,
  output logic [STDIO_XLEN-1:0] stdin_data,
  input  logic [DATA_W-1:0]     rx_data,
  input  logic                  rx_valid,
  output logic [DATA_W-1:0]     tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
`ifdef STDIO_COUNT_EN
  output logic [31:0]           rx_count,
  output logic [31:0]           tx_count,
`endif
  output logic                  rx_overflow
);

  stdio_state_e          state_q, state_d;
  logic [STDIO_XLEN-1:0] stdin_data_q, stdin_data_d;
  logic [DATA_W-1:0]     tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  rx_overflow_q, rx_overflow_d;

  logic                  fifo_pop;
  logic [DATA_W-1:0]     fifo_pop_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_overflow;
  logic [STDIO_XLEN-1:0] fifo_head_zext;

  stdio_rx_fifo #(
    .RX_DEPTH (RX_DEPTH),
    .DATA_W   (DATA_W)
  ) u_rx_fifo (
    .clk            (clk),
    .rstn           (rstn),
    .push           (rx_valid),
    .push_data      (rx_data),
    .pop            (fifo_pop),
    .pop_data       (fifo_pop_data),
    .full           (fifo_full),
    .empty          (fifo_empty),
    .overflow_pulse (fifo_overflow)
  );

  assign fifo_head_zext = {{(STDIO_XLEN-DATA_W){1'b0}}, fifo_pop_data};

  // DONE is the commit cycle, so the core sees stall low exactly once per transfer.
  assign stall = (stdin_read_enable | stdout_write_enable) & (state_q != DONE);

  always_comb begin
    state_d      = state_q;
    stdin_data_d = stdin_data_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    fifo_pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (stdin_read_enable) begin
          if (!fifo_empty) begin
            fifo_pop     = 1'b1;
            stdin_data_d = fifo_head_zext;
            state_d      = DONE;
          end else begin
            state_d = RX_WAIT;
          end
        end else if (stdout_write_enable) begin
          tx_data_d = stdout_data[DATA_W-1:0];
          if (!tx_busy) begin
            tx_start_d = 1'b1;
            state_d    = DONE;
          end else begin
            state_d = TX_WAIT;
          end
        end
      end
      RX_WAIT: begin
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          stdin_data_d = fifo_head_zext;
          state_d      = DONE;
        end
      end
      TX_WAIT: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rx_overflow_d = rx_overflow_q | fifo_overflow;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      stdin_data_q  <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      rx_overflow_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      stdin_data_q  <= stdin_data_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      rx_overflow_q <= rx_overflow_d;
    end
  end

  assign stdin_data  = stdin_data_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign rx_overflow = rx_overflow_q;

`ifdef STDIO_COUNT_EN
  logic [31:0] rx_count_q, rx_count_d;
  logic [31:0] tx_count_q, tx_count_d;

  // Counted on the same edge that pops / raises tx_start, so they show in the DONE cycle.
  always_comb begin
    rx_count_d = rx_count_q;
    tx_count_d = tx_count_q;
    if (fifo_pop)   rx_count_d = rx_count_q + 32'd1;
    if (tx_start_d) tx_count_d = tx_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_count_q <= '0;
      tx_count_q <= '0;
    end else begin
      rx_count_q <= rx_count_d;
      tx_count_q <= tx_count_d;
    end
  end

  assign rx_count = rx_count_q;
  assign tx_count = tx_count_q;
`endif

endmodule

// File: tb/tb_stdio_controller.sv
// Bench for stdio_controller: directed scenarios plus random traffic against a
// transaction-level model (byte queue, sticky overflow, per-instruction commit).
module tb_stdio_controller;

  localparam int RX_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rd_en, wr_en, rx_valid, tx_busy;
  logic [31:0] wdata;
  logic [7:0]  rx_data;
  logic        stall, tx_start, rx_overflow;
  logic [31:0] stdin_data;
  logic [7:0]  tx_data;
`ifdef STDIO_COUNT_EN
  logic [31:0] rx_count, tx_count;
`endif

  always #5 clk = ~clk;

  stdio_controller #(.RX_DEPTH(RX_DEPTH), .DATA_W(8)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .stdin_read_enable   (rd_en),
    .stdout_write_enable (wr_en),
    .stdout_data         (wdata),
    .stall               (stall),
    .stdin_data          (stdin_data),
    .rx_data             (rx_data),
    .rx_valid            (rx_valid),
    .tx_data             (tx_data),
    .tx_start            (tx_start),
    .tx_busy             (tx_busy),
`ifdef STDIO_COUNT_EN
    .rx_count            (rx_count),
    .tx_count            (tx_count),
`endif
    .rx_overflow         (rx_overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: bytes waiting in the UART buffer, plus what the core should see.
  logic [7:0]  m_q [$];
  bit          m_ovf, m_done, m_txstart, last_done;
  logic [31:0] m_stdin, m_rxcnt, m_txcnt;
  logic [7:0]  m_txdata;

  logic        o_stall, o_txstart, o_ovf;
  logic [31:0] o_stdin;
  logic [7:0]  o_txdata;

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0; m_done = 0; m_txstart = 0; last_done = 0;
    m_stdin = '0; m_txdata = '0; m_rxcnt = '0; m_txcnt = '0;
  endtask

  // One clock cycle with the inputs already driven: check at negedge, advance model at posedge.
  task automatic step();
    bit          pop_now, start_now;
    logic [31:0] new_stdin;
    @(negedge clk);
    o_stall = stall; o_stdin = stdin_data; o_txdata = tx_data;
    o_txstart = tx_start; o_ovf = rx_overflow;
    check("stall",       32'(o_stall),   32'((rd_en | wr_en) & ~m_done));
    check("stdin_data",  o_stdin,        m_stdin);
    check("tx_data",     32'(o_txdata),  32'(m_txdata));
    check("tx_start",    32'(o_txstart), 32'(m_txstart));
    check("rx_overflow", 32'(o_ovf),     32'(m_ovf));
`ifdef STDIO_COUNT_EN
    check("rx_count", rx_count, m_rxcnt);
    check("tx_count", tx_count, m_txcnt);
`endif
    @(posedge clk);
    pop_now   = !m_done && rd_en && (m_q.size() > 0);
    start_now = !m_done && wr_en && !rd_en && !tx_busy;
    new_stdin = m_stdin;
    if (pop_now) begin
      new_stdin = {24'h0, m_q.pop_front()};
      m_rxcnt++;
    end
    if (!m_done && wr_en && !rd_en) m_txdata = wdata[7:0];
    if (rx_valid) begin
      if (m_q.size() < RX_DEPTH) m_q.push_back(rx_data);
      else m_ovf = 1;
    end
    if (start_now) m_txcnt++;
    last_done = m_done;
    m_done    = pop_now || start_now;
    m_txstart = start_now;
    m_stdin   = new_stdin;
    #1;
  endtask

  // Called at posedge+1; asserts reset mid-cycle, keeping wr_en as given.
  task automatic apply_reset(input bit keep_wr);
    rstn = 1'b0; rd_en = 0; rx_valid = 0; wr_en = keep_wr;
    #1;
    model_reset();
    check("rst_stall",    32'(stall),       32'(keep_wr));
    check("rst_tx_start", 32'(tx_start),    32'h0);
    check("rst_overflow", 32'(rx_overflow), 32'h0);
    check("rst_stdin",    stdin_data,       32'h0);
    check("rst_tx_data",  32'(tx_data),     32'h0);
    tx_busy = 0;
    @(negedge clk);
    check("rst_tx_start_hold", 32'(tx_start), 32'h0);
    rstn = 1'b1; wr_en = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rd_en = 0; wr_en = 0; rx_valid = 0;
    repeat (n) step();
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_valid = 1; rx_data = b;
    step();
    rx_valid = 0;
  endtask

  task automatic stdin_read(output logic [31:0] val);
    bit done = 0;
    val = 'x;
    rd_en = 1;
    for (int i = 0; i < 50 && !done; i++) begin
      step();
      if (last_done) begin
        val  = o_stdin;
        done = 1;
      end
    end
    rd_en = 0;
    check("stdin_read_done", 32'(done), 32'h1);
  endtask

  task automatic stdout_write(input logic [31:0] d, input int busy_cycles);
    wr_en = 1; wdata = d; tx_busy = 1;
    for (int i = 0; i < busy_cycles + 10 && !last_done; i++) begin
      tx_busy = (i < busy_cycles);
      step();
    end
    wr_en = 0; tx_busy = 0;
  endtask

  logic [31:0] val;
  int          pulses, pulse_at, done_at, first_free;
  int          op;

  initial begin
    rstn = 0; rd_en = 0; wr_en = 0; rx_valid = 0; tx_busy = 0;
    wdata = '0; rx_data = '0;
    model_reset();
    @(posedge clk); #1;
    apply_reset(0);
    idle(2);

    // Buffered byte: one stall cycle, then commit with the byte.
    push_byte(8'h41);
    idle(1);
    rd_en = 1;
    step();
    check("t1_stall_first", 32'(o_stall), 32'h1);
    step();
    check("t1_stall_done", 32'(o_stall), 32'h0);
    check("t1_stdin", o_stdin, 32'h0000_0041);
    rd_en = 0;
    idle(1);

    // Empty FIFO: wait, then the byte commits two cycles after it arrives.
    rd_en = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_stall_wait", 32'(o_stall), 32'h1);
    end
    rx_valid = 1; rx_data = 8'h7A;
    step();
    check("t2_stall_arrive", 32'(o_stall), 32'h1);
    rx_valid = 0;
    step();
    check("t2_stall_pop", 32'(o_stall), 32'h1);
    step();
    check("t2_stall_done", 32'(o_stall), 32'h0);
    check("t2_stdin", o_stdin, 32'h0000_007A);
    rd_en = 0;
    idle(1);

    // STDOUT behind a busy transmitter.
    pulses = 0; pulse_at = -1; done_at = -1; first_free = 3;
    wr_en = 1; wdata = 32'h1234_5648;
    for (int i = 0; i < 8; i++) begin
      tx_busy = (i < 3);
      if (done_at >= 0) wr_en = 0;
      step();
      if (o_txstart) begin
        pulses++;
        pulse_at = i;
        check("t3_tx_data_at_start", 32'(o_txdata), 32'h48);
      end
      if (wr_en && !o_stall && done_at < 0) done_at = i;
    end
    check("t3_pulses", 32'(pulses), 32'd1);
    check("t3_pulse_timing", 32'(pulse_at == first_free || pulse_at == first_free + 1), 32'h1);
    check("t3_stall_drop", 32'(done_at), 32'(first_free + 1));
    check("t3_tx_data", 32'(tx_data), 32'h48);
    tx_busy = 0;

    // Overflow: fifth byte dropped, four reads return the first four.
    apply_reset(0);
    for (int b = 1; b <= 5; b++) push_byte(8'(b));
    check("t4_overflow", 32'(o_ovf), 32'h0);
    idle(1);
    check("t4_overflow_set", 32'(o_ovf), 32'h1);
    for (int b = 1; b <= 4; b++) begin
      stdin_read(val);
      check("t4_read", val, 32'(b));
      idle(1);
    end

    // Push and pop together while full: nothing is dropped.
    apply_reset(0);
    for (int b = 0; b < 4; b++) push_byte(8'h11 + 8'(b));
    rd_en = 1; rx_valid = 1; rx_data = 8'h99;
    step();
    rx_valid = 0;
    step();
    check("t4b_first", o_stdin, 32'h11);
    rd_en = 0;
    idle(1);
    check("t4b_no_overflow", 32'(o_ovf), 32'h0);
    stdin_read(val); check("t4b_read1", val, 32'h12); idle(1);
    stdin_read(val); check("t4b_read2", val, 32'h13); idle(1);
    stdin_read(val); check("t4b_read3", val, 32'h14); idle(1);
    stdin_read(val); check("t4b_read4", val, 32'h99); idle(1);

    // Reset during TX_WAIT with a full, overflowed FIFO.
    for (int b = 0; b < 5; b++) push_byte(8'hA0 + 8'(b));
    wr_en = 1; wdata = 32'h0000_00C3; tx_busy = 1;
    step(); step();
    apply_reset(1);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (o_txstart) pulses++;
    end
    check("t5_no_tx_start", 32'(pulses), 32'h0);
    check("t5_overflow_clear", 32'(o_ovf), 32'h0);
    rd_en = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_fifo_empty_stall", 32'(o_stall), 32'h1);
    end
    rx_valid = 1; rx_data = 8'h5C;
    step();
    rx_valid = 0;
    step(); step();
    check("t5_read_after_reset", o_stdin, 32'h5C);
    rd_en = 0;
    idle(1);

`ifdef STDIO_COUNT_EN
    apply_reset(0);
    for (int b = 0; b < 3; b++) push_byte(8'h30 + 8'(b));
    for (int b = 0; b < 3; b++) begin stdin_read(val); idle(1); end
    stdout_write(32'h61, 0); idle(1);
    stdout_write(32'h62, 2); idle(1);
    check("t6_rx_count", rx_count, 32'd3);
    check("t6_tx_count", tx_count, 32'd2);
`endif

    // Random traffic: the core issues one instruction at a time and holds it until commit.
    apply_reset(0);
    op = 0;
    for (int c = 0; c < 3000; c++) begin
      if (op == 0 && $urandom_range(0, 2) != 0) begin
        op    = int'($urandom_range(1, 2));
        wdata = $urandom;
      end
      rd_en    = (op == 1);
      wr_en    = (op == 2);
      rx_valid = ($urandom_range(0, 3) == 0);
      rx_data  = 8'($urandom);
      if ($urandom_range(0, 2) == 0) tx_busy = ~tx_busy;
      step();
      if (last_done) op = 0;
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
